// File: rtl/uart_rx_buffer.sv
// Receive-side byte FIFO for a UART. It is a circular buffer of
// {parity flag, byte} entries with a first-word-fall-through head, registered
// occupancy flags, and sticky overrun and interrupt flags.
module uart_rx_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        RxData,
  input  logic                     RxParityError,
  input  logic                     RxDone,
  input  logic                     ReadEnable,
  input  logic                     ClearInterrupt,
  output logic [DATA_W-1:0]        DataOut,
  output logic                     DataParityError,
  output logic                     Empty,
  output logic                     Full,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overrun,
  output logic                     RxInterrupt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wrPtr, rdPtr;
  logic [AW:0]     countNext;
  logic            doWrite, doRead, dropByte;
  logic [DATA_W:0] head;

  // A read is legal only when the buffer holds data. A write is accepted when
  // there is room, or when a pop on the same edge frees a slot.
  always_comb begin
    doRead   = ReadEnable && !Empty;
    doWrite  = RxDone && (!Full || ReadEnable);
    dropByte = RxDone && Full && !ReadEnable;
    countNext = Count;
    case ({doWrite, doRead})
      2'b10:   countNext = Count + 1'b1;
      2'b01:   countNext = Count - 1'b1;
      default: countNext = Count;
    endcase
  end

  // Entry storage. It has no reset because the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (reset && doWrite) mem[wrPtr] <= {RxParityError, RxData};
  end

  // Pointers, occupancy, and flags derived from the next count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
      Empty <= 1'b1;
      Full  <= 1'b0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
      Count <= countNext;
      Empty <= (countNext == '0);
      Full  <= (countNext == FullCount);
    end
  end

  // Sticky status bits. A new set condition wins over a clear on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      Overrun     <= 1'b0;
      RxInterrupt <= 1'b0;
    end else begin
      if (dropByte)            Overrun <= 1'b1;
      else if (ClearInterrupt) Overrun <= 1'b0;
      if (doWrite || dropByte) RxInterrupt <= 1'b1;
      else if (ClearInterrupt) RxInterrupt <= 1'b0;
    end
  end

  // Head entry falls through. Outputs are forced to zero while the buffer is empty.
  always_comb begin
    head            = mem[rdPtr];
    DataOut         = Empty ? '0 : head[DATA_W-1:0];
    DataParityError = Empty ? 1'b0 : head[DATA_W];
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer. A vector table covers the basic flows,
// and hand-written sequences cover fill, overrun, full pass-through and reset.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] RxData;
  logic       RxParityError, RxDone, ReadEnable, ClearInterrupt;
  logic [7:0] DataOut;
  logic       DataParityError, Empty, Full, Overrun, RxInterrupt;
  logic [3:0] Count;

  int checks = 0;
  int failures = 0;

  uart_rx_buffer #(.DEPTH(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .RxData(RxData), .RxParityError(RxParityError),
    .RxDone(RxDone), .ReadEnable(ReadEnable), .ClearInterrupt(ClearInterrupt),
    .DataOut(DataOut), .DataParityError(DataParityError), .Empty(Empty),
    .Full(Full), .Count(Count), .Overrun(Overrun), .RxInterrupt(RxInterrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] data;
    logic       par, done, rd, clr;
    logic [7:0] eData;
    logic       ePar, eEmpty, eFull;
    logic [3:0] eCount;
    logic       eOv, eInt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic [7:0] d, logic p, logic dn,
                              logic rd, logic c, logic [7:0] ed, logic ep, logic ee,
                              logic ef, logic [3:0] ec, logic eo, logic ei);
    vec_t v;
    v.name = n; v.rst = r; v.data = d; v.par = p; v.done = dn; v.rd = rd; v.clr = c;
    v.eData = ed; v.ePar = ep; v.eEmpty = ee; v.eFull = ef; v.eCount = ec;
    v.eOv = eo; v.eInt = ei;
    return v;
  endfunction

  // Drive inputs away from the edge, clock once, then sample just after the edge.
  task automatic apply(logic r, logic [7:0] d, logic p, logic dn, logic rd, logic c);
    reset = r; RxData = d; RxParityError = p; RxDone = dn; ReadEnable = rd;
    ClearInterrupt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string n, logic [7:0] ed, logic ep, logic ee, logic ef,
                       logic [3:0] ec, logic eo, logic ei);
    logic [16:0] act, exp;
    act = {DataOut, DataParityError, Empty, Full, Count, Overrun, RxInterrupt};
    exp = {ed, ep, ee, ef, ec, eo, ei};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got data=%h par=%b empty=%b full=%b count=%0d ov=%b int=%b, want data=%h par=%b empty=%b full=%b count=%0d ov=%b int=%b",
               n, DataOut, DataParityError, Empty, Full, Count, Overrun, RxInterrupt,
               ed, ep, ee, ef, ec, eo, ei);
    end
  endtask

  initial begin
    reset = 1'b0; RxData = '0; RxParityError = 1'b0; RxDone = 1'b0;
    ReadEnable = 1'b0; ClearInterrupt = 1'b0;

    //            name          rst data p  dn rd c   eData ep ee ef cnt eo ei
    vecs.push_back(mk("reset",    0, 8'h00,0, 0, 0, 0,  8'h00,0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("idle",     1, 8'h00,0, 0, 0, 0,  8'h00,0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("wr41",     1, 8'h41,0, 1, 0, 0,  8'h41,0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("rd41",     1, 8'h00,0, 0, 1, 0,  8'h00,0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("clr1",     1, 8'h00,0, 0, 0, 1,  8'h00,0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("wr10",     1, 8'h10,0, 1, 0, 0,  8'h10,0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("wr20p",    1, 8'h20,1, 1, 0, 0,  8'h10,0, 0, 0, 2, 0, 1));
    vecs.push_back(mk("wr30",     1, 8'h30,0, 1, 0, 0,  8'h10,0, 0, 0, 3, 0, 1));
    vecs.push_back(mk("rd10",     1, 8'h00,0, 0, 1, 0,  8'h20,1, 0, 0, 2, 0, 1));
    vecs.push_back(mk("rd20",     1, 8'h00,0, 0, 1, 0,  8'h30,0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("rd30",     1, 8'h00,0, 0, 1, 0,  8'h00,0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("rdEmpty",  1, 8'h00,0, 0, 1, 0,  8'h00,0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("wrClr",    1, 8'h77,0, 1, 0, 1,  8'h77,0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("clrAlone", 1, 8'h00,0, 0, 0, 1,  8'h77,0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("rwCnt1",   1, 8'h88,1, 1, 1, 0,  8'h88,1, 0, 0, 1, 0, 1));
    vecs.push_back(mk("rd88",     1, 8'h00,0, 0, 1, 0,  8'h00,0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("clr2",     1, 8'h00,0, 0, 0, 1,  8'h00,0, 1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].data, vecs[i].par, vecs[i].done, vecs[i].rd, vecs[i].clr);
      check(vecs[i].name, vecs[i].eData, vecs[i].ePar, vecs[i].eEmpty, vecs[i].eFull,
            vecs[i].eCount, vecs[i].eOv, vecs[i].eInt);
    end

    // Fill to full with 0x00..0x07. The head stays at 0x00 throughout.
    for (int i = 0; i < 8; i++) begin
      apply(1, 8'(i), 0, 1, 0, 0);
      check($sformatf("fill%0d", i), 8'h00, 0, 0, (i == 7), 4'(i + 1), 0, 1);
    end
    // A byte arriving at full with no pop is dropped.
    apply(1, 8'hFF, 0, 1, 0, 0);
    check("dropFF", 8'h00, 0, 0, 1, 4'd8, 1, 1);
    // At full, a simultaneous push and pop both happen.
    apply(1, 8'hAA, 0, 1, 1, 0);
    check("fullRW", 8'h01, 0, 0, 1, 4'd8, 1, 1);
    // Drain the buffer: expect 0x01..0x07, then 0xAA. 0xFF must never appear.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] nxt;
      nxt = (i < 6) ? 8'(i + 2) : ((i == 6) ? 8'hAA : 8'h00);
      apply(1, 8'h00, 0, 0, 1, 0);
      check($sformatf("drain%0d", i), nxt, 0, (i == 7), 0, 4'(7 - i), 1, 1);
    end
    apply(1, 8'h00, 0, 0, 0, 1);
    check("clrOv", 8'h00, 0, 1, 0, 4'd0, 0, 0);

    // Reset in the middle of operation discards the entries and takes priority over RxDone.
    for (int i = 0; i < 5; i++) apply(1, 8'(8'h50 + i), 0, 1, 0, 0);
    check("pre-reset", 8'h50, 0, 0, 0, 4'd5, 0, 1);
    apply(0, 8'h99, 0, 1, 0, 0);
    check("midReset", 8'h00, 0, 1, 0, 4'd0, 0, 0);
    apply(1, 8'h55, 0, 1, 0, 0);
    check("wr55", 8'h55, 0, 0, 0, 4'd1, 0, 1);
    apply(1, 8'h00, 0, 0, 1, 0);
    check("rd55", 8'h00, 0, 1, 0, 4'd0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
